// File: rtl/game_ctrl.sv
// Game-control stage: collision and scoring against the current pipe, the
// IDLE/PLAY/DYING/OVER state machine and the control strobes back to bird and pipe.
module game_ctrl #(
    parameter int N            = 10,
    parameter int BIRD_SIZE    = 15,
    parameter int PIPE_W       = 40,
    parameter int FLOOR_Y      = 470,
    parameter int DEATH_CYCLES = 24,
    parameter int SCORE_MAX    = 999
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_flap,
    input  logic signed [N-1:0] bird_x,
    input  logic signed [N-1:0] bird_yb,
    input  logic signed [N-1:0] bird_yt,
    input  logic signed [N-1:0] pipe_x,
    input  logic signed [N-1:0] gap_top,
    input  logic signed [N-1:0] gap_bot,
    output logic                bird_reset,
    output logic                flap,
    output logic                pipe_en,
    output logic [1:0]          state,
    output logic                hit,
    output logic [9:0]          score,
    output logic [9:0]          hi_score
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPlay  = 2'd1,
        StDying = 2'd2,
        StOver  = 2'd3
    } state_e;

    localparam int CntW = (DEATH_CYCLES > 1) ? $clog2(DEATH_CYCLES) : 1;
    localparam logic [CntW-1:0]    CntLast  = CntW'(DEATH_CYCLES - 1);
    localparam logic signed [N:0]  BirdOff  = (N+1)'(BIRD_SIZE - 1);
    localparam logic signed [N:0]  PipeOff  = (N+1)'(PIPE_W - 1);
    localparam logic signed [N:0]  FloorLim = (N+1)'(FLOOR_Y);
    localparam logic [9:0]         ScoreMax = 10'(SCORE_MAX);
    // Nothing compares greater than the largest positive value, so this acts
    // like loading pipe_x at reset: no spurious wrap on the first cycle.
    localparam logic signed [N-1:0] PrevRst = {1'b0, {(N-1){1'b1}}};

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [9:0]            score_q, score_d;
    logic [9:0]            hi_q, hi_d;
    logic                  scored_q, scored_d;
    logic                  hit_q, hit_d;
    logic                  bird_reset_q, bird_reset_d;
    logic signed [N-1:0]   prev_pipe_x_q, prev_pipe_x_d;

    logic signed [N:0] bx_l, bx_r, px_l, px_r, yt, yb, gt, gb;
    logic              h_overlap, collision, passed, wrapped;

    always_comb begin
        bx_l      = {bird_x[N-1], bird_x};
        bx_r      = bx_l + BirdOff;
        px_l      = {pipe_x[N-1], pipe_x};
        px_r      = px_l + PipeOff;
        yt        = {bird_yt[N-1], bird_yt};
        yb        = {bird_yb[N-1], bird_yb};
        gt        = {gap_top[N-1], gap_top};
        gb        = {gap_bot[N-1], gap_bot};
        h_overlap = (bx_l <= px_r) && (bx_r >= px_l);
        collision = (h_overlap && ((yt < gt) || (yb > gb))) || (yb >= FloorLim);
        passed    = px_r < bx_l;
        wrapped   = pipe_x > prev_pipe_x_q;
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        score_d       = score_q;
        hi_d          = hi_q;
        scored_d      = scored_q;
        hit_d         = hit_q;
        bird_reset_d  = 1'b0;
        prev_pipe_x_d = pipe_x;
        unique case (state_q)
            StIdle: begin
                hit_d = 1'b0;
                if (key_flap) begin
                    state_d  = StPlay;
                    score_d  = 10'd0;
                    scored_d = 1'b0;
                end
            end
            StPlay: begin
                hit_d = collision;
                if (wrapped) scored_d = 1'b0;
                if (passed && !scored_q) begin
                    score_d  = (score_q < ScoreMax) ? score_q + 10'd1 : ScoreMax;
                    scored_d = 1'b1;
                end
                if (hit_q) begin
                    state_d = StDying;
                    cnt_d   = '0;
                end
            end
            StDying: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = StOver;
                    if (score_q > hi_q) hi_d = score_q;
                end
            end
            StOver: begin
                if (key_flap) begin
                    state_d      = StIdle;
                    bird_reset_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            score_q       <= 10'd0;
            hi_q          <= 10'd0;
            scored_q      <= 1'b0;
            hit_q         <= 1'b0;
            bird_reset_q  <= 1'b1;
            prev_pipe_x_q <= PrevRst;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            score_q       <= score_d;
            hi_q          <= hi_d;
            scored_q      <= scored_d;
            hit_q         <= hit_d;
            bird_reset_q  <= bird_reset_d;
            prev_pipe_x_q <= prev_pipe_x_d;
        end
    end

    assign state      = state_q;
    assign hit        = hit_q;
    assign score      = score_q;
    assign hi_score   = hi_q;
    assign bird_reset = bird_reset_q;
    assign pipe_en    = (state_q == StPlay);
    // Combinational so the bird reacts in the same cycle as the key press.
    assign flap       = key_flap && (state_q == StPlay);

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: reset, scoring, collision, death timer, restart,
// saturation and asynchronous mid-game reset.
module tb_game_ctrl;

    logic              clk;
    logic              reset;
    logic              key_flap;
    logic signed [9:0] bird_x, bird_yb, bird_yt, pipe_x, gap_top, gap_bot;
    logic              bird_reset, flap, pipe_en, hit;
    logic [1:0]        state;
    logic [9:0]        score, hi_score;

    int n_tests = 0;
    int n_fail  = 0;

    game_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .key_flap   (key_flap),
        .bird_x     (bird_x),
        .bird_yb    (bird_yb),
        .bird_yt    (bird_yt),
        .pipe_x     (pipe_x),
        .gap_top    (gap_top),
        .gap_bot    (gap_bot),
        .bird_reset (bird_reset),
        .flap       (flap),
        .pipe_en    (pipe_en),
        .state      (state),
        .hit        (hit),
        .score      (score),
        .hi_score   (hi_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called on the first cycle observed in DYING; ends on the first cycle in OVER.
    task automatic run_dying(input int exp_hi);
        check("dying_entry", 32'(state), 2);
        for (int i = 0; i < 23; i++) begin
            if (i == 10) begin
                key_flap = 1'b1;
                #1;
                check("dying_flap_blocked", 32'(flap), 0);
            end
            step();
            key_flap = 1'b0;
            check("dying_hold", 32'(state), 2);
        end
        step();
        check("over_entry", 32'(state), 3);
        check("over_hi", 32'(hi_score), 32'(exp_hi));
        check("over_hit_held", 32'(hit), 1);
    endtask

    initial begin
        reset    = 1'b1;
        key_flap = 1'b0;
        bird_x   = 10'sd160;
        bird_yt  = 10'sd233;
        bird_yb  = 10'sd247;
        gap_top  = 10'sd200;
        gap_bot  = 10'sd300;
        pipe_x   = 10'sd300;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_score", 32'(score), 0);
        check("rst_hi", 32'(hi_score), 0);
        check("rst_bird_reset", 32'(bird_reset), 1);
        check("rst_pipe_en", 32'(pipe_en), 0);
        check("rst_hit", 32'(hit), 0);

        reset = 1'b1;
        step();
        check("rel_bird_reset", 32'(bird_reset), 0);
        check("rel_state", 32'(state), 0);

        // Start pulse is swallowed, later pulses pass through in PLAY
        key_flap = 1'b1;
        #1;
        check("idle_flap", 32'(flap), 0);
        step();
        key_flap = 1'b0;
        check("start_state", 32'(state), 1);
        check("start_pipe_en", 32'(pipe_en), 1);
        key_flap = 1'b1;
        #1;
        check("play_flap", 32'(flap), 1);
        key_flap = 1'b0;

        // Pipe sweep through the gap: scores once when its right edge 159 < 160
        for (int p = 200; p >= 100; p--) begin
            pipe_x = 10'(p);
            step();
            check("sweep_hit", 32'(hit), 0);
            check("sweep_score", 32'(score), (p <= 120) ? 1 : 0);
        end
        pipe_x = 10'sd500;
        step();
        check("wrap_score", 32'(score), 1);
        pipe_x = 10'sd120;
        step();
        check("second_pass", 32'(score), 2);

        // Narrow gap: bird top 233 above gap_top 250 while overlapping
        gap_top = 10'sd250;
        gap_bot = 10'sd350;
        pipe_x  = 10'sd150;
        step();
        check("pipe_hit", 32'(hit), 1);
        check("pipe_hit_state", 32'(state), 1);
        step();
        gap_top = 10'sd200;
        gap_bot = 10'sd300;
        pipe_x  = 10'sd300;
        run_dying(2);
        check("over_score", 32'(score), 2);

        key_flap = 1'b1;
        step();
        key_flap = 1'b0;
        check("restart_state", 32'(state), 0);
        check("restart_bird_reset", 32'(bird_reset), 1);
        check("restart_hi", 32'(hi_score), 2);
        step();
        check("bird_reset_pulse", 32'(bird_reset), 0);
        check("idle_hit_clear", 32'(hit), 0);

        // Floor collision with no pipe overlap
        key_flap = 1'b1;
        step();
        key_flap = 1'b0;
        check("floor_start", 32'(state), 1);
        check("floor_score0", 32'(score), 0);
        bird_yb = 10'sd470;
        step();
        check("floor_hit", 32'(hit), 1);
        step();
        bird_yb = 10'sd247;
        run_dying(2);

        // Held key: first cycle leaves OVER, second starts PLAY
        key_flap = 1'b1;
        step();
        check("hold_idle", 32'(state), 0);
        check("hold_bird_reset", 32'(bird_reset), 1);
        step();
        key_flap = 1'b0;
        check("hold_play", 32'(state), 1);
        check("hold_bird_reset_off", 32'(bird_reset), 0);

        // Saturation at 999
        for (int k = 1; k <= 1001; k++) begin
            pipe_x = 10'sd500;
            step();
            pipe_x = 10'sd120;
            step();
            if (k == 998) check("sat_998", 32'(score), 998);
            if (k == 999) check("sat_999", 32'(score), 999);
            if (k == 1001) check("sat_hold", 32'(score), 999);
        end
        check("sat_state", 32'(state), 1);

        // Asynchronous reset between clock edges
        reset = 1'b0;
        #2;
        check("async_state", 32'(state), 0);
        check("async_score", 32'(score), 0);
        check("async_hi", 32'(hi_score), 0);
        check("async_bird_reset", 32'(bird_reset), 1);
        check("async_pipe_en", 32'(pipe_en), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
